line_burst_arbiter: RTL and testbench

//  Sits between the L1 icache/dcache line ports and the top-level burst memory port (mem_*).

---
 rtl/line_burst_arbiter.sv | 116 +++++++++++
 tb/tb_line_burst_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/line_burst_arbiter.sv
// Arbitrates icache/dcache line requests onto a single burst memory port,
// moving each 256-bit line as four 64-bit beats (beat 0 = bits 63:0).
module line_burst_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 256,
  parameter int BEAT_W     = 64,
  parameter int D_PRIORITY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_line_read,
  input  logic [ADDR_W-1:0] i_line_addr,
  output logic [LINE_W-1:0] i_line_rdata,
  output logic              i_line_resp,
  input  logic              d_line_read,
  input  logic              d_line_write,
  input  logic [ADDR_W-1:0] d_line_addr,
  input  logic [LINE_W-1:0] d_line_wdata,
  output logic [LINE_W-1:0] d_line_rdata,
  output logic              d_line_resp,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [BEAT_W-1:0] mem_wdata,
  input  logic [BEAT_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  localparam int BEATS = LINE_W / BEAT_W;
  localparam int CNT_W = $clog2(BEATS);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_W / 8 - 1);

  typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, DONE} state_t;

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         cnt_q;
  logic [ADDR_W-1:0]        addr_q;
  logic                     owner_d_q;
  logic [LINE_W-1:0]        wline_q;
  logic [LINE_W-BEAT_W-1:0] asm_q;
  logic [LINE_W-1:0]        i_rdata_q, d_rdata_q;

  logic d_req, grant_d, grant_i, busy, last_beat;

  always_comb begin
    d_req     = d_line_read | d_line_write;
    grant_d   = d_req && ((D_PRIORITY != 0) || !i_line_read);
    grant_i   = i_line_read && !grant_d;
    busy      = (state_q == I_RD) || (state_q == D_RD) || (state_q == D_WR);
    last_beat = busy && mem_resp && (cnt_q == CNT_W'(BEATS - 1));

    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d)      state_d = d_line_write ? D_WR : D_RD;
        else if (grant_i) state_d = I_RD;
      end
      I_RD, D_RD, D_WR: if (last_beat) state_d = DONE;
      DONE:             state_d = IDLE;
      default:          state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      owner_d_q <= 1'b0;
      wline_q   <= '0;
      asm_q     <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE) begin
        if (grant_d) begin
          addr_q    <= d_line_addr & LINE_MASK;
          owner_d_q <= 1'b1;
          if (d_line_write) wline_q <= d_line_wdata;
        end else if (grant_i) begin
          addr_q    <= i_line_addr & LINE_MASK;
          owner_d_q <= 1'b0;
        end
      end
      if (busy && mem_resp) begin
        cnt_q <= cnt_q + 1'b1;
        for (int unsigned b = 0; b < BEATS - 1; b++)
          if (cnt_q == CNT_W'(b)) asm_q[b*BEAT_W +: BEAT_W] <= mem_rdata;
      end
      // Final beat goes straight into the owner's line so rdata only changes on completion.
      if (last_beat && state_q == I_RD) i_rdata_q <= {mem_rdata, asm_q};
      if (last_beat && state_q == D_RD) d_rdata_q <= {mem_rdata, asm_q};
    end
  end

  always_comb begin
    mem_addr     = addr_q;
    mem_read     = (state_q == I_RD) || (state_q == D_RD);
    mem_write    = (state_q == D_WR);
    mem_wdata    = (state_q == D_WR) ? wline_q[cnt_q*BEAT_W +: BEAT_W] : '0;
    i_line_resp  = (state_q == DONE) && !owner_d_q;
    d_line_resp  = (state_q == DONE) && owner_d_q;
    i_line_rdata = i_rdata_q;
    d_line_rdata = d_rdata_q;
  end

  a_no_rd_wr_both: assert property (@(posedge clk) disable iff (rst)
    !(state_q == IDLE && d_line_read && d_line_write))
    else $error("line_burst_arbiter: d_line_read and d_line_write both high");

  a_no_stray_resp: assert property (@(posedge clk) disable iff (rst)
    !((state_q == IDLE || state_q == DONE) && mem_resp))
    else $error("line_burst_arbiter: mem_resp while no burst is active");

endmodule

// File: tb/tb_line_burst_arbiter.sv
// Directed and randomized checks of line_burst_arbiter against a line-level model.
module tb_line_burst_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_line_read;
  logic [31:0]  i_line_addr;
  logic [255:0] i_line_rdata;
  logic         i_line_resp;
  logic         d_line_read;
  logic         d_line_write;
  logic [31:0]  d_line_addr;
  logic [255:0] d_line_wdata;
  logic [255:0] d_line_rdata;
  logic         d_line_resp;
  logic [31:0]  mem_addr;
  logic         mem_read;
  logic         mem_write;
  logic [63:0]  mem_wdata;
  logic [63:0]  mem_rdata;
  logic         mem_resp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int grant_cyc, last_beat_cyc;
  bit beat_mode;
  logic [255:0] exp_i, exp_d;

  line_burst_arbiter #(
    .ADDR_W(32), .LINE_W(256), .BEAT_W(64), .D_PRIORITY(1)
  ) dut (
    .clk(clk), .rst(rst),
    .i_line_read(i_line_read), .i_line_addr(i_line_addr),
    .i_line_rdata(i_line_rdata), .i_line_resp(i_line_resp),
    .d_line_read(d_line_read), .d_line_write(d_line_write),
    .d_line_addr(d_line_addr), .d_line_wdata(d_line_wdata),
    .d_line_rdata(d_line_rdata), .d_line_resp(d_line_resp),
    .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    check("no_rd_wr_overlap", mem_read & mem_write, 1'b0);
  endtask

  // One whole line transaction; the arbiter must be idle on entry.
  task automatic do_line(input bit is_d, input bit is_wr, input logic [31:0] addr,
                         input logic [255:0] wl, input logic [15:0] pat,
                         input int pat_len, input bit rnd_gaps);
    logic [255:0] line;
    logic [63:0]  beat;
    logic [31:0]  a_exp;
    bit           r;
    int           k, n;
    a_exp = {addr[31:5], 5'b0};
    line  = '0;
    check("idle_rd", mem_read, 1'b0);
    check("idle_wr", mem_write, 1'b0);
    if (is_d) begin
      d_line_addr = addr; d_line_read = !is_wr; d_line_write = is_wr; d_line_wdata = wl;
    end else begin
      i_line_addr = addr; i_line_read = 1'b1;
    end
    step();
    grant_cyc = cyc;
    check("grant_rd", mem_read, !is_wr);
    check("grant_wr", mem_write, is_wr);
    check("grant_addr", mem_addr, a_exp);
    k = 0; n = 0;
    while (k < 4 && n < 40) begin
      if (n < pat_len)  r = pat[n];
      else if (rnd_gaps) r = ($urandom_range(0, 2) != 0);
      else              r = 1'b1;
      beat = beat_mode ? 64'h1111_1111_1111_1111 * (k + 1) : {$urandom, $urandom};
      mem_resp = r; mem_rdata = beat;
      if (is_wr) check("wdata", mem_wdata, wl[k*64 +: 64]);
      step();
      n++;
      mem_resp = 1'b0;
      if (r) begin
        line[k*64 +: 64] = beat;
        k++;
      end
      if (k == 4) last_beat_cyc = cyc;
      else begin
        check("burst_addr", mem_addr, a_exp);
        check("burst_rd", mem_read, !is_wr);
        check("early_iresp", i_line_resp, 1'b0);
        check("early_dresp", d_line_resp, 1'b0);
      end
    end
    if (k < 4) check("beat_timeout", k, 4);
    check("done_iresp", i_line_resp, !is_d);
    check("done_dresp", d_line_resp, is_d);
    check("done_rd", mem_read, 1'b0);
    check("done_wr", mem_write, 1'b0);
    if (!is_wr) begin
      if (is_d) exp_d = line;
      else      exp_i = line;
    end
    check("i_rdata", i_line_rdata, exp_i);
    check("d_rdata", d_line_rdata, exp_d);
    if (is_d) begin
      d_line_read = 1'b0; d_line_write = 1'b0;
    end else
      i_line_read = 1'b0;
    step();
    check("post_iresp", i_line_resp, 1'b0);
    check("post_dresp", d_line_resp, 1'b0);
    check("post_rd", mem_read, 1'b0);
  endtask

  initial begin
    int first_last;
    logic [255:0] wl;
    rst = 1'b1;
    i_line_read = 0; i_line_addr = '0; d_line_read = 0; d_line_write = 0;
    d_line_addr = '0; d_line_wdata = '0; mem_rdata = '0; mem_resp = 0;
    exp_i = '0; exp_d = '0; beat_mode = 1'b1;
    #1;
    check("rst_rd", mem_read, 1'b0);
    check("rst_wr", mem_write, 1'b0);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 64'h0);
    check("rst_iresp", i_line_resp, 1'b0);
    check("rst_irdata", i_line_rdata, 256'h0);
    check("rst_drdata", d_line_rdata, 256'h0);
    step(); step();
    rst = 1'b0;
    step();

    // icache read with the repeated-digit beat pattern
    do_line(1'b0, 1'b0, 32'h0000_0064, '0, 16'h0, 0, 1'b0);
    check("i_line_const", i_line_rdata,
          {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
           64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111});
    beat_mode = 1'b0;

    wl = 256'h0123456789ABCDEF_FEDCBA9876543210_0011223344556677_0123456789ABCDEF;
    do_line(1'b1, 1'b1, 32'h8000_0020, wl, 16'h0, 0, 1'b0);

    // simultaneous requests: dcache first, icache granted from the following idle cycle
    i_line_read = 1'b1; i_line_addr = 32'h0000_1100;
    do_line(1'b1, 1'b0, 32'h0000_2200, '0, 16'h0, 0, 1'b0);
    first_last = last_beat_cyc;
    do_line(1'b0, 1'b0, 32'h0000_1100, '0, 16'h0, 0, 1'b0);
    check("prio_gap", grant_cyc - first_last, 2);

    // gaps 1,0,0,1,1,0,1
    do_line(1'b1, 1'b0, 32'h0000_3344, '0, 16'b1011001, 7, 1'b0);

    // reset in the middle of a d-read
    d_line_addr = 32'h1000_0040; d_line_read = 1'b1;
    step();
    check("rst_mid_grant", mem_read, 1'b1);
    mem_resp = 1'b1; mem_rdata = 64'hDEAD_BEEF_0000_0001;
    step(); step();
    mem_resp = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_mid_rd", mem_read, 1'b0);
    check("rst_mid_dresp", d_line_resp, 1'b0);
    check("rst_mid_drdata", d_line_rdata, 256'h0);
    check("rst_mid_irdata", i_line_rdata, 256'h0);
    exp_i = '0; exp_d = '0;
    d_line_read = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    do_line(1'b1, 1'b0, 32'h1000_0040, '0, 16'h0, 0, 1'b0);

    // back-to-back icache reads
    do_line(1'b0, 1'b0, 32'h0000_0040, '0, 16'h0, 0, 1'b0);
    first_last = last_beat_cyc;
    do_line(1'b0, 1'b0, 32'h0000_0060, '0, 16'h0, 0, 1'b0);
    check("b2b_gap", grant_cyc - first_last, 2);

    for (int t = 0; t < 24; t++) begin
      bit is_d, is_wr;
      is_d  = $urandom_range(0, 1) != 0;
      is_wr = is_d && ($urandom_range(0, 1) != 0);
      wl    = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      do_line(is_d, is_wr, $urandom, wl, 16'h0, 0, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
